// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM state type, the counter-width helper and the legal operand-width range.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 32;

    function automatic int unsigned CNT_W(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mult_signfix.sv
// Splits a W-bit operand into an unsigned magnitude and a sign bit.
// When is_signed is low the value passes through unchanged with sign=0.
module seq_mult_signfix #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] value,
    input  logic         is_signed,
    output logic [W-1:0] magnitude,
    output logic         sign
);

    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude
    always_comb begin
        sign      = is_signed & value[W-1];
        magnitude = sign ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential NxN shift-add multiplier with valid/ready handshakes, signed or unsigned per operation.
// Define SEQMUL_EARLY_TERM_EN to finish as soon as no set multiplier bits remain.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = CNT_W(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
        $error("seq_multiplier: N out of range");
    end

    state_e           state_q, state_d;
    logic [N-1:0]     a_mag_q, a_mag_d;
    logic [N-1:0]     b_mag_q, b_mag_d;
    logic             neg_q, neg_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   product_q, product_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [N-1:0]     a_mag_in, b_mag_in;
    logic             a_sign, b_sign;
    logic [2*N-1:0]   addend, acc_sum;
    logic             last_step;

    seq_mult_signfix #(.W(N)) u_fix_a (
        .value     (multiplicand),
        .is_signed (is_signed),
        .magnitude (a_mag_in),
        .sign      (a_sign)
    );

    seq_mult_signfix #(.W(N)) u_fix_b (
        .value     (multiplier),
        .is_signed (is_signed),
        .magnitude (b_mag_in),
        .sign      (b_sign)
    );

    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        addend    = '0;
        acc_sum   = acc_q;
        last_step = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_mag_d = a_mag_in;
                    b_mag_d = b_mag_in;
                    neg_d   = a_sign ^ b_sign;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (|(b_mag_q & (ONE_N << cnt_q)))
                    addend = {{N{1'b0}}, a_mag_q} << cnt_q;
                acc_sum = acc_q + addend;
                acc_d   = acc_sum;
                cnt_d   = cnt_q + CW'(1);
`ifdef SEQMUL_EARLY_TERM_EN
                last_step = (cnt_q == CW'(N - 1)) || (((b_mag_q >> cnt_q) >> 1) == '0);
`else
                last_step = (cnt_q == CW'(N - 1));
`endif
                // The result is registered from this step's sum, so DONE already sees it
                if (last_step) begin
                    product_d = neg_q ? (~acc_sum + {{(2*N-1){1'b0}}, 1'b1}) : acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: N=4 exhaustive and N=8 handshake, reset and throughput cases.
// Latency expectations follow SEQMUL_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       in_valid4, in_ready4, is_signed4, out_valid4, out_ready4;
    logic [3:0] mc4, mp4;
    logic [7:0] product4;

    logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
    logic [7:0]  mc8, mp8;
    logic [15:0] product8;

    seq_multiplier #(.N(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid4),
        .in_ready     (in_ready4),
        .multiplicand (mc4),
        .multiplier   (mp4),
        .is_signed    (is_signed4),
        .out_valid    (out_valid4),
        .out_ready    (out_ready4),
        .product      (product4)
    );

    seq_multiplier #(.N(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .multiplicand (mc8),
        .multiplier   (mp8),
        .is_signed    (is_signed8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .product      (product8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int unsigned mag, input int n);
`ifdef SEQMUL_EARLY_TERM_EN
        int l = 1;
        for (int i = 0; i < n; i++)
            if (mag[i]) l = i + 1;
        return l;
`else
        return n;
`endif
    endfunction

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] exp_p, input int exp_l, input string tag);
        int lat;
        in_valid4 = 1'b1; mc4 = a; mp4 = b; is_signed4 = s; out_ready4 = 1'b1;
        chk($sformatf("%s %0h*%0h in_ready", tag, a, b), in_ready4, 1);
        @(posedge clk); @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk($sformatf("%s %0h*%0h latency", tag, a, b), lat, exp_l);
        chk($sformatf("%s %0h*%0h product", tag, a, b), product4, exp_p);
        @(posedge clk); @(negedge clk);
        chk($sformatf("%s %0h*%0h out_valid drop", tag, a, b), out_valid4, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp_p, input int exp_l, input string tag);
        int lat;
        in_valid8 = 1'b1; mc8 = a; mp8 = b; is_signed8 = s; out_ready8 = 1'b1;
        chk({tag, " in_ready"}, in_ready8, 1);
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, exp_l);
        chk({tag, " product"}, product8, exp_p);
        @(posedge clk); @(negedge clk);
        chk({tag, " out_valid drop"}, out_valid8, 0);
    endtask

    initial begin
        int lat;
        int sa, sb;
        int idx, ridx;
        int acc_t[3];
        logic [7:0]  qa[3];
        logic [7:0]  qb[3];
        logic [15:0] qp[3];

        reset = 1'b1;
        in_valid4 = 1'b0; mc4 = '0; mp4 = '0; is_signed4 = 1'b0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; mc8 = '0; mp8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid8", out_valid8, 0);
        chk("reset product8", product8, 0);
        chk("reset product4", product4, 0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post-reset in_ready8", in_ready8, 1);
        chk("post-reset in_ready4", in_ready4, 1);

        // N=4 boundary vectors with literal results
        op4(4'h8, 4'h8, 1'b1, 8'h40, exp_lat(8, 4), "s4 -8*-8");
        op4(4'h8, 4'h7, 1'b1, 8'hC8, exp_lat(7, 4), "s4 -8*7");
        op4(4'hF, 4'h1, 1'b1, 8'hFF, exp_lat(1, 4), "s4 -1*1");
        op4(4'h0, 4'h8, 1'b1, 8'h00, exp_lat(8, 4), "s4 0*-8");
        op4(4'hF, 4'hF, 1'b0, 8'd225, exp_lat(15, 4), "u4 15*15");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(4'(a), 4'(b), 1'b0, 8'(a * b), exp_lat(b, 4), "u4");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                sa = (a > 7) ? a - 16 : a;
                sb = (b > 7) ? b - 16 : b;
                op4(4'(a), 4'(b), 1'b1, 8'(sa * sb), exp_lat((sb < 0) ? -sb : sb, 4), "s4");
            end

        // Backpressure: result held while out_ready is low, new requests ignored
        in_valid8 = 1'b1; mc8 = 8'd200; mp8 = 8'd3; is_signed8 = 1'b0; out_ready8 = 1'b0;
        chk("bp in_ready", in_ready8, 1);
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("bp latency", lat, exp_lat(3, 8));
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_valid8 = 1'b1; mc8 = 8'd7; mp8 = 8'd7; end
            if (i == 9) in_valid8 = 1'b0;
            chk($sformatf("bp stall %0d out_valid", i), out_valid8, 1);
            chk($sformatf("bp stall %0d product", i), product8, 16'd600);
            chk($sformatf("bp stall %0d in_ready", i), in_ready8, 0);
            @(posedge clk); @(negedge clk);
        end
        out_ready8 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp release out_valid", out_valid8, 0);
        chk("bp release in_ready", in_ready8, 1);
        chk("bp product hold", product8, 16'd600);
        op8(8'd5, 8'd6, 1'b0, 16'd30, exp_lat(6, 8), "bp next 5*6");

        // Reset in the middle of 255*255
        in_valid8 = 1'b1; mc8 = 8'd255; mp8 = 8'd255; is_signed8 = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midreset out_valid", out_valid8, 0);
        chk("midreset product", product8, 0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midreset in_ready", in_ready8, 1);
        op8(8'd2, 8'd3, 1'b0, 16'd6, exp_lat(3, 8), "after reset 2*3");

        op8(8'h80, 8'h80, 1'b1, 16'h4000, exp_lat(128, 8), "s8 -128*-128");
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, exp_lat(127, 8), "s8 -128*127");
        op8(8'd77, 8'd0, 1'b0, 16'd0, exp_lat(0, 8), "u8 77*0");
        op8(8'd77, 8'd1, 1'b0, 16'd77, exp_lat(1, 8), "u8 77*1");
        op8(8'd77, 8'd128, 1'b0, 16'd9856, exp_lat(128, 8), "u8 77*128");
        op8(8'hFD, 8'd2, 1'b1, 16'hFFFA, exp_lat(2, 8), "s8 -3*2");
`ifdef SEQMUL_EARLY_TERM_EN
        op8(8'd77, 8'd0, 1'b0, 16'd0, 1, "et 77*0");
        op8(8'd77, 8'd1, 1'b0, 16'd77, 1, "et 77*1");
        op8(8'd77, 8'd128, 1'b0, 16'd9856, 8, "et 77*128");
        op8(8'hFD, 8'd2, 1'b1, 16'hFFFA, 2, "et -3*2");
`endif

        // Back-to-back with in_valid and out_ready held high
        qa[0] = 8'd10;  qb[0] = 8'd20;  qp[0] = 16'd200;
        qa[1] = 8'd100; qb[1] = 8'd200; qp[1] = 16'd20000;
        qa[2] = 8'd255; qb[2] = 8'd2;   qp[2] = 16'd510;
        idx = 0; ridx = 0;
        out_ready8 = 1'b1; is_signed8 = 1'b0;
        for (int cyc = 0; cyc < 200 && ridx < 3; cyc++) begin
            if (idx < 3) begin mc8 = qa[idx]; mp8 = qb[idx]; end
            in_valid8 = (idx < 3);
            if (out_valid8) begin
                chk($sformatf("b2b result %0d", ridx), product8, qp[ridx]);
                ridx++;
            end
            if (in_ready8 && idx < 3) begin
                acc_t[idx] = cyc;
                idx++;
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid8 = 1'b0;
        chk("b2b results returned", ridx, 3);
        chk("b2b spacing 0-1", acc_t[1] - acc_t[0], exp_lat(20, 8) + 2);
        chk("b2b spacing 1-2", acc_t[2] - acc_t[1], exp_lat(200, 8) + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential NxN multiplier. It is the iterative successor to the combinational NxN multiplier.
- Computes a 2N-bit product using one shift-add step per clock.
- Each operation can be unsigned or two's-complement signed.
- Uses valid/ready handshakes on both input and output, so it can sit in a datapath pipeline where area matters more than latency.

Parameters:
- N, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- multiplicand  input  N  operand A.
- multiplier  input  N  operand B.
- is_signed  input  1  1 = treat A and B as two's complement; 0 = unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream accepts the product.
- product  output  2N  result; unsigned or two's complement according to the latched is_signed.

Behaviour:
- Reset: synchronous and active-high; applied on the clock edge.
  - State goes to IDLE; out_valid=0, product=0, internal accumulator and counter are cleared.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch A, B and is_signed.
  - If signed: store |A| and |B| as N-bit magnitudes and neg = A[N-1]^B[N-1]. Otherwise neg=0 and the raw operands are used.
  - Clear the 2N-bit accumulator and count=0, then go to BUSY.
- BUSY:
  - Each cycle: if B-magnitude bit[count]=1, acc += |A| << count (2N-bit add, no overflow possible).
  - count++. After the step with count=N-1, go to DONE.
  - On that same edge, register product = neg ? -acc : acc (2N-bit two's complement).
  - in_ready=0.
- DONE:
  - out_valid=1; product is stable and held until out_valid & out_ready.
  - On handshake: go to IDLE with out_valid=0. product holds its last value.
  - in_ready=0 in DONE, so there is no overlap of operations.
- Latency and throughput:
  - out_valid rises exactly N cycles after the accepting edge.
  - Back-to-back throughput is one operation per N+2 cycles when out_ready is held high.
- Boundaries:
  - Signed -2^(N-1) has magnitude 2^(N-1), which fits in N unsigned bits.
  - (-2^(N-1))*(-2^(N-1)) = 2^(2N-2) is representable in 2N signed bits.
  - Zero operands take the full latency.
  - out_ready held low stalls DONE indefinitely; inputs are ignored meanwhile.
  - in_valid while not in IDLE has no effect.
- Product values must be bit-exact with A*B evaluated at 2N width, signed or unsigned per mode.

Optional Feature:
- Macro: SEQMUL_EARLY_TERM_EN.
- Defined: BUSY exits to DONE as soon as the remaining unprocessed magnitude bits of B are all zero, checked after each step.
  - Latency = max(1, position of highest set bit of |B| + 1) cycles.
  - A |B|=0 operation completes in 1 cycle.
  - Handshake rules are unchanged.
- Undefined: fixed latency of N cycles for every operation.

Decomposition:
- Package seq_mult_pkg holds:
  - the state enum type (IDLE, BUSY, DONE);
  - the counter-width function CNT_W(N) = $clog2(N+1);
  - the parameter legality check constants.
- One natural sub-module, seq_mult_signfix:
  - combinational, parametrised width W;
  - input value and signed flag; outputs magnitude and sign bit;
  - instantiated for A and B.
  - The final conditional negate stays inline.

Test Plan:
- N=4 unsigned exhaustive: all 256 A,B pairs, out_ready=1. Each product equals A*B, e.g. 15*15 -> 8'd225; out_valid appears exactly 4 cycles after accept.
- N=4 signed exhaustive: -8*-8 -> 8'sd64, -8*7 -> -56 (8'hC8), -1*1 -> 8'hFF, 0*-8 -> 0.
- N=8 backpressure: accept 200*3, hold out_ready=0 for 20 cycles.
  - product stays 16'd600 with out_valid=1 throughout; in_ready=0.
  - A new in_valid during the stall is ignored.
  - After out_ready=1, the next op is accepted in IDLE.
- Reset mid-operation: N=8, assert reset 3 cycles after accepting 255*255.
  - Next cycle: out_valid=0, product=0.
  - in_ready=1 the cycle after reset drops.
  - A following 2*3 returns 6.
- Back-to-back: N=8, in_valid and out_ready held high with 3 queued ops.
  - Accepts are spaced exactly N+2=10 cycles apart.
  - Results are returned in order.
- With SEQMUL_EARLY_TERM_EN, N=8:
  - 77*0 completes in 1 cycle.
  - 77*1 completes in 1 cycle.
  - 77*128 completes in 8 cycles with product 16'd9856.
  - Signed -3*2 completes in 2 cycles with product 16'hFFFA.
